hash_msg_sequencer: RTL and testbench
=====================================

Name: hash_msg_sequencer

Overview:
- Upstream controller for the bent-function LFSR hash core.
- Accepts a byte-oriented message over a valid/ready stream and serialises it MSB-first onto the core's single-bit lfsr_in_injector.
- Appends a '1' marker and a byte-count length field, then runs a fixed number of zero-injection finalisation cycles.
- Captures the core's output O as the digest and holds it until the consumer accepts it.

Parameters:
- DIGEST_W, 32: width of core O and of the digest register; equals the core's lfsr_out_size.
- LEN_W, 16: width of the appended message byte-count field.
- FINAL_CYCLES, 64: number of zero-injection squeeze cycles before capture; must be >= 1.
- CNT_W, 7: width of the squeeze counter; must satisfy 2^CNT_W > FINAL_CYCLES.

Ports:
- clk  in  1  single clock for the block and the hash core.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a new message; honoured only in IDLE.
- in_data  in  8  message byte.
- in_valid  in  1  in_data is valid.
- in_last  in  1  qualifies the final byte of the message.
- in_ready  out  1  block can accept a byte this cycle.
- lfsr_in_injector  out  1  serial bit to the hash core.
- core_reset  out  1  reset to the hash core.
- core_o  in  DIGEST_W  hash core output O.
- digest  out  DIGEST_W  captured hash value.
- digest_valid  out  1  digest holds a result.
- digest_ready  in  1  consumer accepts the digest.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; in_ready, lfsr_in_injector, digest_valid, busy = 0; digest = 0; byte counter, bit counter and squeeze counter cleared.
- core_reset = reset OR (state==CLR). This is the only combinational path from reset to an output.
- States: IDLE -> CLR -> ABSORB -> PAD -> SQUEEZE -> DONE -> IDLE.
- IDLE:
  - start=1 -> CLR.
  - in_valid is ignored; in_ready=0.
- CLR: one cycle; core_reset=1; -> ABSORB.
- ABSORB:
  - Handshake rule: a byte is accepted at a clock edge where in_valid & in_ready are both 1. It loads an 8-bit shift register and bits_left=8.
  - The following 8 cycles drive lfsr_in_injector = shreg[7], shifting left each cycle.
  - in_ready=1 when bits_left is 0 or 1 and the last byte has not yet been accepted. This allows gap-free back-to-back bytes.
  - When bits_left==0 and no byte is loaded, lfsr_in_injector=0 (bubble). The core still clocks during bubbles.
  - Byte counter increments per accepted byte and saturates at 2^LEN_W-1.
  - After the in_last byte's final bit -> PAD.
  - Zero-length messages are not supported; every message carries at least one byte.
- PAD: 1+LEN_W cycles. Inject '1', then the byte count MSB-first. in_ready=0. -> SQUEEZE.
- SQUEEZE: FINAL_CYCLES cycles injecting 0. On the last squeeze cycle's edge, digest <= core_o and digest_valid <= 1. -> DONE.
- DONE:
  - digest and digest_valid are held stable.
  - On digest_valid & digest_ready -> IDLE; digest_valid <= 0. digest retains its value.
- Total injection cycles per message = 8N + 1 + LEN_W + FINAL_CYCLES (no bubbles). Bubble cycles are extra.
- start while busy is ignored.
- in_last is ignored unless it is accompanied by a handshake.
- Reset mid-operation aborts immediately. Any partial byte is discarded, and core_reset is held for the reset duration.

Decomposition:
- Shared package/include hash_seq_pkg:
  - state encoding (IDLE=0, CLR=1, ABSORB=2, PAD=3, SQUEEZE=4, DONE=5);
  - default LEN_W, FINAL_CYCLES and DIGEST_W constants, kept consistent with the hash-core generator arguments.
- One sub-module, bit_serializer: 8-bit parallel-load, MSB-first shift register with bits_left counter, load/shift/empty signals and async reset.
- FSM, counters and digest register stay in hash_msg_sequencer.

Test Plan:
- Single byte 0xA5, defaults:
  - injector after CLR = 1,0,1,0,0,1,0,1;
  - then 1, then 0x0001 as sixteen bits (15 zeros, then 1);
  - then 64 zeros;
  - digest_valid rises exactly 89 cycles after ABSORB entry; digest equals core_o sampled on that edge.
- Back-to-back bytes 0x00,0xFF,0x3C with in_valid held high: no bubble cycles; exactly 24 message bits; length field 0x0003.
- Producer gap: 2 idle cycles between bytes 0x81 and 0x7E: exactly 2 zero bubbles injected; length field 0x0002; total injection 8*2+1+16+64+2 = 99 cycles.
- Digest backpressure: digest_ready low for 10 cycles after digest_valid: digest stable and busy=1 throughout; IDLE reached on the cycle after the handshake; a start during DONE is ignored.
- Reset mid-ABSORB (after 3 bits of 0xF0): all outputs cleared immediately; core_reset high during reset; a new start then produces the single-byte sequence from scratch.
- Saturation with LEN_W=4: message of 17 bytes: length field 0xF (1111).

Source files
------------

// File: rtl/hash_seq_pkg.sv
// Shared constants and state encoding for the hash message sequencer.
// Default widths track the bent-function LFSR hash-core generator arguments.
package hash_seq_pkg;

  localparam int unsigned DIGEST_W_DEF     = 32;
  localparam int unsigned LEN_W_DEF        = 16;
  localparam int unsigned FINAL_CYCLES_DEF = 64;
  localparam int unsigned CNT_W_DEF        = 7;
  localparam int unsigned BYTE_W           = 8;
  localparam int unsigned BIT_CNT_W        = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLR     = 3'd1,
    ST_ABSORB  = 3'd2,
    ST_PAD     = 3'd3,
    ST_SQUEEZE = 3'd4,
    ST_DONE    = 3'd5
  } seq_state_e;

endpackage

// File: rtl/bit_serializer.sv
// MSB-first byte serializer: parallel load, one bit per shift,
// bits_left tracks how many bits of the loaded byte remain.
module bit_serializer
  import hash_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 shift,
  input  logic [BYTE_W-1:0]    load_data,
  output logic                 msb,
  output logic [BIT_CNT_W-1:0] bits_left,
  output logic                 empty_c
);

  logic [BYTE_W-1:0] shreg;

  // A load wins over a shift so the next byte follows the last bit gap-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg     <= '0;
      bits_left <= '0;
    end else if (load) begin
      shreg     <= load_data;
      bits_left <= BIT_CNT_W'(BYTE_W);
    end else if (shift && !empty_c) begin
      shreg     <= {shreg[BYTE_W-2:0], 1'b0};
      bits_left <= bits_left - BIT_CNT_W'(1);
    end
  end

  assign msb     = shreg[BYTE_W-1];
  assign empty_c = (bits_left == '0);

endmodule

// File: rtl/hash_msg_sequencer.sv
// Feeds a byte stream bit-serially into the LFSR hash core, appends marker,
// byte-count and zero squeeze cycles, then captures and holds the digest.
module hash_msg_sequencer
  import hash_seq_pkg::*;
#(
  parameter int unsigned DIGEST_W     = DIGEST_W_DEF,
  parameter int unsigned LEN_W        = LEN_W_DEF,
  parameter int unsigned FINAL_CYCLES = FINAL_CYCLES_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [BYTE_W-1:0]   in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic                lfsr_in_injector,
  output logic                core_reset,
  input  logic [DIGEST_W-1:0] core_o,
  output logic [DIGEST_W-1:0] digest,
  output logic                digest_valid,
  input  logic                digest_ready,
  output logic                busy
);

  localparam int unsigned PAD_W = $clog2(LEN_W + 1);

  seq_state_e           state;
  seq_state_e           state_nxt;
  logic [LEN_W-1:0]     len_cnt;
  logic [PAD_W-1:0]     pad_cnt;
  logic [CNT_W-1:0]     sq_cnt;
  logic                 last_seen;
  logic                 hs;
  logic                 capture;
  logic                 ser_shift;
  logic                 ser_msb;
  logic                 ser_empty;
  logic [BIT_CNT_W-1:0] bits_left;

  bit_serializer u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (hs),
    .shift     (ser_shift),
    .load_data (in_data),
    .msb       (ser_msb),
    .bits_left (bits_left),
    .empty_c   (ser_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and per-cycle injector/ready decode.
  always_comb begin
    state_nxt        = state;
    in_ready         = 1'b0;
    lfsr_in_injector = 1'b0;
    ser_shift        = 1'b0;
    capture          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_CLR;
      end
      ST_CLR: begin
        // First byte may load here so its MSB lands on the first ABSORB cycle.
        in_ready  = 1'b1;
        state_nxt = ST_ABSORB;
      end
      ST_ABSORB: begin
        in_ready         = (bits_left <= BIT_CNT_W'(1)) && !last_seen;
        lfsr_in_injector = !ser_empty && ser_msb;
        ser_shift        = 1'b1;
        if (last_seen && (bits_left == BIT_CNT_W'(1))) state_nxt = ST_PAD;
      end
      ST_PAD: begin
        lfsr_in_injector = (pad_cnt == '0) ? 1'b1 : len_cnt[LEN_W-1];
        if (pad_cnt == PAD_W'(LEN_W)) state_nxt = ST_SQUEEZE;
      end
      ST_SQUEEZE: begin
        if (sq_cnt == CNT_W'(FINAL_CYCLES - 1)) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (digest_valid && digest_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    hs = in_valid && in_ready;
  end

  // Counters, length field shifter and digest register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_cnt      <= '0;
      last_seen    <= 1'b0;
      pad_cnt      <= '0;
      sq_cnt       <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      busy <= (state_nxt != ST_IDLE);
      if (state == ST_IDLE) begin
        len_cnt   <= '0;
        last_seen <= 1'b0;
      end else if (hs) begin
        if (len_cnt != '1) len_cnt <= len_cnt + LEN_W'(1);
        if (in_last) last_seen <= 1'b1;
      end else if ((state == ST_PAD) && (pad_cnt != '0)) begin
        // The byte count doubles as the shift register for the length field.
        len_cnt <= len_cnt << 1;
      end
      pad_cnt <= (state == ST_PAD) ? pad_cnt + PAD_W'(1) : '0;
      sq_cnt  <= (state == ST_SQUEEZE) ? sq_cnt + CNT_W'(1) : '0;
      if (capture) begin
        digest       <= core_o;
        digest_valid <= 1'b1;
      end else if (digest_valid && digest_ready) begin
        digest_valid <= 1'b0;
      end
    end
  end

  assign core_reset = reset || (state == ST_CLR);

endmodule

// File: tb/tb_hash_msg_sequencer.sv
// Directed bench for hash_msg_sequencer: expected injector streams are queued
// as bytes are driven and compared against the recorded stream per message.
module tb_hash_msg_sequencer;

  localparam int unsigned DW  = 32;
  localparam int unsigned LW  = 16;
  localparam int unsigned LW2 = 4;
  localparam int unsigned FC  = 64;

  logic          clk          = 1'b0;
  logic          reset        = 1'b1;
  logic          start        = 1'b0;
  logic [7:0]    in_data      = '0;
  logic          in_valid     = 1'b0;
  logic          in_last      = 1'b0;
  logic          digest_ready = 1'b1;
  logic [DW-1:0] core_o       = '0;

  logic          in_ready, inj, core_reset, digest_valid, busy;
  logic [DW-1:0] digest;
  logic          in_ready2, inj2, core_reset2, digest_valid2, busy2;
  logic [DW-1:0] digest2;

  int            total = 0;
  int            bad   = 0;
  bit            exp_q[$];
  bit            exp2_q[$];
  bit            rec_q[$];
  bit            rec2_q[$];
  bit            mon_on = 1'b0, mon2_on = 1'b0, mon_done = 1'b0, mon2_done = 1'b0;
  logic [DW-1:0] exp_dig = '0, exp_dig2 = '0;
  logic [7:0]    m[$];

  always #5 clk = ~clk;

  hash_msg_sequencer u_dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .lfsr_in_injector(inj), .core_reset(core_reset),
    .core_o(core_o), .digest(digest), .digest_valid(digest_valid),
    .digest_ready(digest_ready), .busy(busy)
  );

  hash_msg_sequencer #(.LEN_W(LW2)) u_dut_sat (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready2), .lfsr_in_injector(inj2), .core_reset(core_reset2),
    .core_o(core_o), .digest(digest2), .digest_valid(digest_valid2),
    .digest_ready(digest_ready), .busy(busy2)
  );

  // Record each injected bit from ABSORB entry until digest_valid, then move core_o on.
  always @(negedge clk) begin
    if (reset) begin
      mon_on = 1'b0; mon2_on = 1'b0; mon_done = 1'b0; mon2_done = 1'b0;
    end else begin
      if (core_reset) begin
        mon_on = 1'b1; mon_done = 1'b0; rec_q.delete();
      end else if (mon_on) begin
        if (digest_valid) begin
          mon_on = 1'b0; mon_done = 1'b1; exp_dig = core_o;
        end else rec_q.push_back(inj);
      end
      if (core_reset2) begin
        mon2_on = 1'b1; mon2_done = 1'b0; rec2_q.delete();
      end else if (mon2_on) begin
        if (digest_valid2) begin
          mon2_on = 1'b0; mon2_done = 1'b1; exp_dig2 = core_o;
        end else rec2_q.push_back(inj2);
      end
    end
    core_o = DW'($urandom);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // sel: 0 = both queues, 1 = default DUT only, 2 = LEN_W=4 DUT only.
  task automatic push_bits(input logic [63:0] v, input int n, input int sel);
    for (int k = n - 1; k >= 0; k--) begin
      if (sel != 2) exp_q.push_back(v[k]);
      if (sel != 1) exp2_q.push_back(v[k]);
    end
  endtask

  task automatic push_tail(input int n);
    push_bits(64'(1), 1, 0);
    push_bits(64'(n), LW, 1);
    push_bits(64'((n > 15) ? 15 : n), LW2, 2);
    push_bits(64'(0), FC, 0);
  endtask

  task automatic send_msg(input logic [7:0] msg[$], input int bubbles);
    int wait_cyc;
    bit hs;
    exp_q.delete(); exp2_q.delete();
    in_data = msg[0]; in_valid = 1'b1; in_last = (msg.size() == 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    foreach (msg[i]) begin
      in_data = msg[i]; in_valid = 1'b1; in_last = (i == msg.size() - 1);
      hs = 1'b0; wait_cyc = 0;
      while (!hs && wait_cyc < 40) begin
        @(negedge clk); hs = in_ready;
        @(posedge clk); #1; wait_cyc++;
      end
      check("handshake", 64'(hs), 64'(1));
      push_bits(64'(msg[i]), 8, 0);
      in_valid = 1'b0; in_last = 1'b0;
      if ((i != msg.size() - 1) && bubbles > 0) begin
        push_bits(64'(0), bubbles, 0);
        repeat (7 + bubbles) begin @(posedge clk); #1; end
      end
    end
    push_tail(msg.size());
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (!(mon_done && mon2_done) && c < budget) begin
      @(posedge clk); #1; c++;
    end
    check("digest_arrival", 64'(mon_done & mon2_done), 64'(1));
  endtask

  task automatic cmp_stream(input string tag, input int n1, input int n2);
    int bad1 = -1;
    int bad2 = -1;
    check({tag, "_cycles"}, 64'(rec_q.size()), 64'(n1));
    check({tag, "_cycles_sat"}, 64'(rec2_q.size()), 64'(n2));
    check({tag, "_len"}, 64'(rec_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rec_q.size(); i++)
      if (bad1 < 0 && rec_q[i] !== exp_q[i]) bad1 = i;
    for (int i = 0; i < exp2_q.size() && i < rec2_q.size(); i++)
      if (bad2 < 0 && rec2_q[i] !== exp2_q[i]) bad2 = i;
    check({tag, "_stream_first_bad_plus1"}, 64'(bad1 + 1), 64'(0));
    check({tag, "_stream_sat_first_bad_plus1"}, 64'(bad2 + 1), 64'(0));
    check({tag, "_digest"}, 64'(digest), 64'(exp_dig));
    check({tag, "_digest_sat"}, 64'(digest2), 64'(exp_dig2));
    check({tag, "_idle"}, 64'({busy, digest_valid}), 64'(0));
  endtask

  initial begin
    logic [3:0] sat_len;
    repeat (3) @(posedge clk);
    #1;
    check("rst_core_reset", 64'(core_reset), 64'(1));
    check("rst_outputs", 64'({busy, in_ready, inj, digest_valid}), 64'(0));
    check("rst_digest", 64'(digest), 64'(0));
    check("rst_outputs_sat", 64'({core_reset2, busy2, in_ready2, inj2, digest_valid2}), 64'(5'b10000));
    reset = 1'b0;
    #1;
    check("rel_core_reset", 64'(core_reset), 64'(0));
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 64'({in_ready, busy}), 64'(0));

    // Single byte 0xA5.
    m.delete(); m.push_back(8'hA5);
    send_msg(m, 0); wait_done(400);
    cmp_stream("a5", 89, 77);

    // Back-to-back bytes with in_valid held high.
    m.delete(); m.push_back(8'h00); m.push_back(8'hFF); m.push_back(8'h3C);
    send_msg(m, 0); wait_done(400);
    cmp_stream("b2b", 105, 93);

    // Producer gap giving two bubble cycles.
    m.delete(); m.push_back(8'h81); m.push_back(8'h7E);
    send_msg(m, 2); wait_done(400);
    cmp_stream("gap", 99, 87);

    // Digest backpressure with an ignored start in DONE.
    digest_ready = 1'b0;
    m.delete(); m.push_back(8'h5A);
    send_msg(m, 0); wait_done(400);
    for (int i = 0; i < 10; i++) begin
      check("bp_digest", 64'(digest), 64'(exp_dig));
      check("bp_busy_valid", 64'({busy, digest_valid}), 64'(2'b11));
      check("bp_no_clr", 64'(core_reset), 64'(0));
      if (i == 4) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    digest_ready = 1'b1;
    @(posedge clk); #1;
    cmp_stream("bp", 89, 77);
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_stays_idle", 64'({busy, core_reset}), 64'(0));
    end

    // Reset in the middle of absorbing 0xF0.
    m.delete(); m.push_back(8'hF0);
    send_msg(m, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("mid_pre_reset", 64'({busy, inj}), 64'(2'b11));
    reset = 1'b1;
    #1;
    check("mid_rst_outputs", 64'({busy, in_ready, inj, digest_valid}), 64'(0));
    check("mid_rst_digest", 64'(digest), 64'(0));
    check("mid_rst_core_reset", 64'(core_reset), 64'(1));
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_held", 64'(core_reset), 64'(1));
    reset = 1'b0;
    @(posedge clk); #1;
    m.delete(); m.push_back(8'hA5);
    send_msg(m, 0); wait_done(400);
    cmp_stream("after_rst", 89, 77);

    // 17 bytes: the LEN_W=4 instance saturates its length field.
    m.delete();
    for (int i = 0; i < 17; i++) m.push_back(8'(i * 37 + 5));
    send_msg(m, 0); wait_done(600);
    cmp_stream("sat", 217, 205);
    sat_len = '0;
    for (int k = 0; k < 4; k++)
      sat_len = {sat_len[2:0], ((137 + k) < rec2_q.size()) ? rec2_q[137 + k] : 1'b0};
    check("sat_len_field", 64'(sat_len), 64'(4'hF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
